// File: rtl/wisc_pkg.sv
// wisc_pkg
// Shared types and constants for the WISC pipeline hazard logic.
//   REG_IDX_W  : width of a register index (8 architectural registers)
//   NUM_REGS   : number of architectural registers
//   slot_t     : one in-flight pipeline slot {v, wreg, hlt}
//   sb_state_e : hazard controller state {RUN, DRAIN, HALTED}
package wisc_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  // v    : the instruction in this slot writes wreg
  // wreg : destination register index
  // hlt  : the instruction in this slot is HALT (never writes)
  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] wreg;
    logic                 hlt;
  } slot_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundle between the decode stage and the hazard scoreboard.
//   Decode -> scoreboard : id_valid, id_readReg1/2, id_rd1_used/id_rd2_used,
//                          id_writeReg, id_regWrite, id_halt, flush
//   Scoreboard -> decode : stall, bubble_ex, pend_mask, halted, stall_cnt
// The decode side uses the master modport, the scoreboard the slave modport.
interface hazard_scoreboard_if
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_readReg1;
  logic [REG_IDX_W-1:0] id_readReg2;
  logic                 id_rd1_used;
  logic                 id_rd2_used;
  logic [REG_IDX_W-1:0] id_writeReg;
  logic                 id_regWrite;
  logic                 id_halt;
  logic                 flush;

  logic                 stall;
  logic                 bubble_ex;
  logic [NUM_REGS-1:0]  pend_mask;
  logic                 halted;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_readReg1, id_readReg2, id_rd1_used, id_rd2_used,
           id_writeReg, id_regWrite, id_halt, flush,
    input  stall, bubble_ex, pend_mask, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_readReg1, id_readReg2, id_rd1_used, id_rd2_used,
           id_writeReg, id_regWrite, id_halt, flush,
    output stall, bubble_ex, pend_mask, halted, stall_cnt
  );

endinterface

// File: rtl/sb_slot.sv
// sb_slot
// One pipeline-tracking slot of the hazard scoreboard (EX, MEM or WB).
// Loads d on every rising clock edge; cleared to empty by async reset.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   d     : slot contents for the next cycle
//   q     : current slot contents
module sb_slot
  import wisc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t d,
  output slot_t q
);

  // The chain has no enable: instructions leave EX/MEM/WB every cycle,
  // and stalls are represented by empty slots entering EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard controller beside the WISC decode stage. Tracks destination
// registers in flight in EX/MEM/WB, stalls on read-after-write hazards,
// drops the ID instruction on a flush and drains the pipe on HALT.
// No forwarding: the register file writes in the first half-cycle, so an
// instruction in WB never conflicts with a read in ID.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : decode-side bundle (slave modport), see hazard_scoreboard_if
module hazard_scoreboard
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  hz
);

  slot_t               ex_d;
  slot_t               ex_q;
  slot_t               mem_q;
  slot_t               wb_q;

  sb_state_e           state_q;
  sb_state_e           state_d;

  logic                src1_hit;
  logic                src2_hit;
  logic                raw;
  logic                accept;
  logic                stall_c;
  logic                halted_c;
  logic [NUM_REGS-1:0] pend_c;
  logic [CNT_W-1:0]    stall_cnt_q;

  // EX -> MEM -> WB shift chain
  sb_slot u_ex  (.clk(clk), .rst_n(rst_n), .d(ex_d),  .q(ex_q));
  sb_slot u_mem (.clk(clk), .rst_n(rst_n), .d(ex_q),  .q(mem_q));
  sb_slot u_wb  (.clk(clk), .rst_n(rst_n), .d(mem_q), .q(wb_q));

  // Hazard detection. Only EX and MEM matter; R0 is a real register.
  // Flush wins over a hazard so IF can redirect, and once the pipe is
  // draining nothing more is accepted.
  always_comb begin
    src1_hit = hz.id_rd1_used &
               ((ex_q.v  & (ex_q.wreg  == hz.id_readReg1)) |
                (mem_q.v & (mem_q.wreg == hz.id_readReg1)));
    src2_hit = hz.id_rd2_used &
               ((ex_q.v  & (ex_q.wreg  == hz.id_readReg2)) |
                (mem_q.v & (mem_q.wreg == hz.id_readReg2)));
    raw      = src1_hit | src2_hit;
    accept   = hz.id_valid & ~hz.flush & ~raw & (state_q == RUN);
    stall_c  = (raw & hz.id_valid & ~hz.flush) | (state_q != RUN);
  end

  // Next EX slot: the accepted instruction, else an empty bubble.
  // A HALT never marks a register as pending.
  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.v    = hz.id_regWrite & ~hz.id_halt;
      ex_d.wreg = hz.id_writeReg;
      ex_d.hlt  = hz.id_halt;
    end
  end

  // Pending-write view built only from slot registers.
  always_comb begin
    pend_c = '0;
    if (ex_q.v) begin
      pend_c[ex_q.wreg] = 1'b1;
    end
    if (mem_q.v) begin
      pend_c[mem_q.wreg] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. HALTED is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && hz.id_halt) state_d = DRAIN;
      DRAIN:   if (wb_q.hlt)             state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // halted must be visible in the cycle the HALT occupies WB, one cycle
  // before the FSM itself enters HALTED.
  always_comb begin
    halted_c = (state_q == HALTED) | ((state_q == DRAIN) & wb_q.hlt);
  end

  // Saturating count of stalled cycles, including DRAIN and HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hz.stall     = stall_c;
  assign hz.bubble_ex = ~accept;
  assign hz.pend_mask = pend_c;
  assign hz.halted    = halted_c;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard. The reference model tracks,
// per register, the cycle in which its latest writer was accepted and the
// cycle in which a HALT was accepted; hazards, pending writes and the
// halted flag are derived from those cycle distances.
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  // Reference model state
  int last_wr [8];
  int halt_acc;
  int cyc;
  int exp_cnt;

  hazard_scoreboard_if #(.CNT_W(16)) hz ();

  hazard_scoreboard #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A write accepted in cycle a sits in EX at a+1 and MEM at a+2.
  function automatic bit m_pending(input int r);
    return ((cyc - last_wr[r]) >= 1) && ((cyc - last_wr[r]) <= 2);
  endfunction

  function automatic bit m_raw();
    return (hz.id_rd1_used && m_pending(int'(hz.id_readReg1))) ||
           (hz.id_rd2_used && m_pending(int'(hz.id_readReg2)));
  endfunction

  function automatic bit m_stall();
    return (m_raw() && hz.id_valid && !hz.flush) || (halt_acc >= 0);
  endfunction

  function automatic bit m_accept();
    return hz.id_valid && !hz.flush && !m_raw() && (halt_acc < 0);
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] m;
    m = '0;
    for (int r = 0; r < 8; r++) if (m_pending(r)) m[r] = 1'b1;
    return m;
  endfunction

  function automatic bit m_halted();
    return (halt_acc >= 0) && (cyc >= halt_acc + 3);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) last_wr[r] = -100;
    halt_acc = -1;
    cyc      = 0;
    exp_cnt  = 0;
  endtask

  task automatic clear_inputs();
    hz.id_valid    = 1'b0;
    hz.id_readReg1 = '0;
    hz.id_readReg2 = '0;
    hz.id_rd1_used = 1'b0;
    hz.id_rd2_used = 1'b0;
    hz.id_writeReg = '0;
    hz.id_regWrite = 1'b0;
    hz.id_halt     = 1'b0;
    hz.flush       = 1'b0;
  endtask

  // Advance the model by one clock using the current ID inputs, then
  // advance the simulation to just after the rising edge.
  task automatic tick();
    bit acc;
    acc = m_accept();
    if (m_stall() && exp_cnt < 65535) exp_cnt++;
    if (acc) begin
      if (hz.id_halt) halt_acc = cyc;
      else if (hz.id_regWrite) last_wr[hz.id_writeReg] = cyc;
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Presents one instruction in ID until the model accepts it (bounded),
  // counting the cycles the DUT reports stall.
  task automatic issue(input logic [2:0] r1, input bit u1,
                       input logic [2:0] r2, input bit u2,
                       input logic [2:0] wr, input bit rw, input bit hlt,
                       output int stalls, output bit timed_out);
    hz.id_valid    = 1'b1;
    hz.id_readReg1 = r1;
    hz.id_rd1_used = u1;
    hz.id_readReg2 = r2;
    hz.id_rd2_used = u2;
    hz.id_writeReg = wr;
    hz.id_regWrite = rw;
    hz.id_halt     = hlt;
    hz.flush       = 1'b0;
    stalls    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (hz.stall === 1'b1) stalls++;
      if (m_accept()) begin
        timed_out = 1'b0;
        tick();
        break;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (hz.stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall got=%0b exp=0", hz.stall); end
    checks++; if (hz.bubble_ex !== 1'b1) begin failures++; $display("[TB] FAIL rst_bubble got=%0b exp=1", hz.bubble_ex); end
    checks++; if (hz.pend_mask !== 8'h00) begin failures++; $display("[TB] FAIL rst_pend got=%0h exp=00", hz.pend_mask); end
    checks++; if (hz.halted !== 1'b0) begin failures++; $display("[TB] FAIL rst_halted got=%0b exp=0", hz.halted); end
    checks++; if (hz.stall_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL rst_cnt got=%0h exp=0", hz.stall_cnt); end
    rst_n = 1'b1;
    model_reset();
    tick();
    #1;
    checks++; if (hz.stall_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL rst_cnt_after got=%0h exp=0", hz.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    int  s;
    bit  to;
    do_reset();
    issue(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, s, to);
    checks++; if (s !== 0 || to) begin failures++; $display("[TB] FAIL b2b_producer stalls=%0d timeout=%0b exp=0", s, to); end
    // ADD R4,R3,R1 right behind ADD R3
    hz.id_valid    = 1'b1;
    hz.id_readReg1 = 3'd3;
    hz.id_rd1_used = 1'b1;
    hz.id_readReg2 = 3'd1;
    hz.id_rd2_used = 1'b1;
    hz.id_writeReg = 3'd4;
    hz.id_regWrite = 1'b1;
    #1;
    checks++; if ({hz.stall, hz.bubble_ex} !== 2'b11) begin failures++; $display("[TB] FAIL b2b_cyc1 stall,bubble got=%b exp=11", {hz.stall, hz.bubble_ex}); end
    checks++; if (hz.pend_mask !== 8'h08) begin failures++; $display("[TB] FAIL b2b_pend1 got=%0h exp=08", hz.pend_mask); end
    tick();
    #1;
    checks++; if ({hz.stall, hz.bubble_ex} !== 2'b11) begin failures++; $display("[TB] FAIL b2b_cyc2 stall,bubble got=%b exp=11", {hz.stall, hz.bubble_ex}); end
    checks++; if (hz.pend_mask !== 8'h08) begin failures++; $display("[TB] FAIL b2b_pend2 got=%0h exp=08", hz.pend_mask); end
    tick();
    #1;
    checks++; if ({hz.stall, hz.bubble_ex} !== 2'b00) begin failures++; $display("[TB] FAIL b2b_cyc3 stall,bubble got=%b exp=00", {hz.stall, hz.bubble_ex}); end
    checks++; if (hz.stall_cnt !== 16'd2) begin failures++; $display("[TB] FAIL b2b_cnt got=%0d exp=2", hz.stall_cnt); end
    tick();
    clear_inputs();
    #1;
    checks++; if (hz.pend_mask !== 8'h10) begin failures++; $display("[TB] FAIL b2b_consumer_ex got=%0h exp=10", hz.pend_mask); end
    idle(3);
  endtask

  task automatic test_spacing();
    int s;
    bit to;
    do_reset();
    // ADD R3, NOP, SUB reading R3
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, s, to);
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, s, to);
    issue(3'd3, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, s, to);
    checks++; if (s !== 1 || to) begin failures++; $display("[TB] FAIL one_between stalls=%0d timeout=%0b exp=1", s, to); end
    idle(3);
    // write R3 then ST with R3 as store data
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, s, to);
    issue(3'd5, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, s, to);
    checks++; if (s !== 2 || to) begin failures++; $display("[TB] FAIL st_data stalls=%0d timeout=%0b exp=2", s, to); end
    idle(3);
    // two independent instructions between producer and consumer
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, s, to);
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, s, to);
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, s, to);
    issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, s, to);
    checks++; if (s !== 0 || to) begin failures++; $display("[TB] FAIL two_between stalls=%0d timeout=%0b exp=0", s, to); end
    idle(3);
    // R0 is tracked like any other register; unused source never stalls
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, s, to);
    issue(3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b0, s, to);
    checks++; if (s !== 2 || to) begin failures++; $display("[TB] FAIL r0_hazard stalls=%0d timeout=%0b exp=2", s, to); end
    issue(3'd7, 1'b0, 3'd7, 1'b0, 3'd1, 1'b1, 1'b0, s, to);
    checks++; if (s !== 0 || to) begin failures++; $display("[TB] FAIL unused_src stalls=%0d timeout=%0b exp=0", s, to); end
    idle(3);
  endtask

  task automatic test_flush();
    int s;
    bit to;
    do_reset();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, s, to);
    hz.id_valid    = 1'b1;
    hz.id_readReg1 = 3'd2;
    hz.id_rd1_used = 1'b1;
    hz.id_writeReg = 3'd5;
    hz.id_regWrite = 1'b1;
    hz.flush       = 1'b1;
    #1;
    checks++; if ({hz.stall, hz.bubble_ex} !== 2'b01) begin failures++; $display("[TB] FAIL flush_raw stall,bubble got=%b exp=01", {hz.stall, hz.bubble_ex}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (hz.pend_mask !== 8'h04) begin failures++; $display("[TB] FAIL flush_ex_empty got=%0h exp=04", hz.pend_mask); end
    checks++; if (hz.stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL flush_cnt got=%0d exp=0", hz.stall_cnt); end
    // HALT in ID together with flush is dropped
    hz.id_valid = 1'b1;
    hz.id_halt  = 1'b1;
    hz.flush    = 1'b1;
    #1;
    checks++; if ({hz.stall, hz.bubble_ex} !== 2'b01) begin failures++; $display("[TB] FAIL flush_halt stall,bubble got=%b exp=01", {hz.stall, hz.bubble_ex}); end
    tick();
    clear_inputs();
    tick();
    tick();
    tick();
    #1;
    checks++; if ({hz.stall, hz.halted} !== 2'b00) begin failures++; $display("[TB] FAIL flush_halt_run stall,halted got=%b exp=00", {hz.stall, hz.halted}); end
  endtask

  task automatic test_halt();
    do_reset();
    hz.id_valid = 1'b1;
    hz.id_halt  = 1'b1;
    #1;
    checks++; if (hz.bubble_ex !== 1'b0) begin failures++; $display("[TB] FAIL halt_accept bubble got=%0b exp=0", hz.bubble_ex); end
    tick();
    // a later independent instruction waits in ID forever
    clear_inputs();
    hz.id_valid    = 1'b1;
    hz.id_writeReg = 3'd1;
    hz.id_regWrite = 1'b1;
    #1;
    checks++; if ({hz.stall, hz.bubble_ex, hz.halted} !== 3'b110) begin failures++; $display("[TB] FAIL halt_t1 stall,bubble,halted got=%b exp=110", {hz.stall, hz.bubble_ex, hz.halted}); end
    tick();
    #1;
    checks++; if ({hz.stall, hz.bubble_ex, hz.halted} !== 3'b110) begin failures++; $display("[TB] FAIL halt_t2 stall,bubble,halted got=%b exp=110", {hz.stall, hz.bubble_ex, hz.halted}); end
    tick();
    #1;
    checks++; if ({hz.stall, hz.bubble_ex, hz.halted} !== 3'b111) begin failures++; $display("[TB] FAIL halt_t3 stall,bubble,halted got=%b exp=111", {hz.stall, hz.bubble_ex, hz.halted}); end
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++; if ({hz.stall, hz.bubble_ex, hz.halted} !== 3'b111) begin failures++; $display("[TB] FAIL halt_sticky stall,bubble,halted got=%b exp=111", {hz.stall, hz.bubble_ex, hz.halted}); end
    checks++; if (hz.stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL halt_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    // pipeline is HALTED here, so every cycle stalls
    clear_inputs();
    for (int i = 0; i < 70000; i++) tick();
    #1;
    checks++; if (hz.stall_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_cnt got=%0h exp=ffff", hz.stall_cnt); end
    checks++; if (exp_cnt != 65535) begin failures++; $display("[TB] FAIL sat_model got=%0d exp=65535", exp_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    int s;
    bit to;
    do_reset();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, s, to);
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, s, to);
    #1;
    checks++; if ({hz.stall, hz.pend_mask} !== {1'b1, 8'h40}) begin failures++; $display("[TB] FAIL drain_pre stall,pend got=%0h exp=140", {hz.stall, hz.pend_mask}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({hz.halted, hz.stall, hz.bubble_ex} !== 3'b001) begin failures++; $display("[TB] FAIL drain_rst halted,stall,bubble got=%b exp=001", {hz.halted, hz.stall, hz.bubble_ex}); end
    checks++; if (hz.stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL drain_rst_cnt got=%0d exp=0", hz.stall_cnt); end
    checks++; if (hz.pend_mask !== 8'h00) begin failures++; $display("[TB] FAIL drain_rst_pend got=%0h exp=00", hz.pend_mask); end
    rst_n = 1'b1;
    model_reset();
    tick();
    issue(3'd6, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, s, to);
    checks++; if (s !== 0 || to) begin failures++; $display("[TB] FAIL drain_rst_run stalls=%0d timeout=%0b exp=0", s, to); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hz.id_valid    = ($urandom_range(0, 9) < 8);
      hz.id_readReg1 = 3'($urandom_range(0, 7));
      hz.id_readReg2 = 3'($urandom_range(0, 7));
      hz.id_rd1_used = 1'($urandom_range(0, 1));
      hz.id_rd2_used = 1'($urandom_range(0, 1));
      hz.id_writeReg = 3'($urandom_range(0, 7));
      hz.id_regWrite = 1'($urandom_range(0, 1));
      hz.id_halt     = (i > 380) && ($urandom_range(0, 3) == 0);
      hz.flush       = ($urandom_range(0, 6) == 0);
      #1;
      checks++; if (hz.stall !== m_stall()) begin failures++; $display("[TB] FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, hz.stall, m_stall()); end
      checks++; if (hz.bubble_ex !== !m_accept()) begin failures++; $display("[TB] FAIL rnd_bubble cyc=%0d got=%0b exp=%0b", i, hz.bubble_ex, !m_accept()); end
      checks++; if (hz.pend_mask !== m_pend()) begin failures++; $display("[TB] FAIL rnd_pend cyc=%0d got=%0h exp=%0h", i, hz.pend_mask, m_pend()); end
      checks++; if (hz.halted !== m_halted()) begin failures++; $display("[TB] FAIL rnd_halted cyc=%0d got=%0b exp=%0b", i, hz.halted, m_halted()); end
      checks++; if (hz.stall_cnt !== 16'(exp_cnt)) begin failures++; $display("[TB] FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, hz.stall_cnt, exp_cnt); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    model_reset();
    clear_inputs();
    #1;
    test_reset();
    test_back_to_back();
    test_spacing();
    test_flush();
    test_random();
    test_halt();
    test_saturate();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
